// File: rtl/au_pkg.sv
// Shared definitions for the serial add/subtract unit: op encoding, FSM states
// and the flag bundle handed to the flags/branch logic.
package au_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_ADC = 2'b10;
    localparam logic [1:0] OP_SBC = 2'b11;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } au_state_t;

    typedef struct packed {
        logic v;
        logic c;
        logic n;
        logic z;
    } au_flags_t;

endpackage

// File: rtl/au_digit_add.sv
// DIGIT-wide ripple-carry adder used once per cycle by au_serial.
// Ports:
//   a, b   : digit operands
//   cin    : carry into bit 0
//   sum    : digit sum
//   cout   : carry out of the top bit
//   c_msb  : carry into the top bit (feeds signed overflow on the last digit)
module au_digit_add #(
    parameter int unsigned DIGIT = 4
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             cin,
    output logic [DIGIT-1:0] sum,
    output logic             cout,
    output logic             c_msb
);

    logic [DIGIT:0] carry;

    // Bit-serial ripple chain.
    always_comb begin
        sum      = '0;
        carry    = '0;
        carry[0] = cin;
        for (int i = 0; i < int'(DIGIT); i++) begin
            sum[i]       = a[i] ^ b[i] ^ carry[i];
            carry[i+1]   = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
        end
    end

    assign cout  = carry[DIGIT];
    assign c_msb = carry[DIGIT-1];

endmodule

// File: rtl/au_serial.sv
// Multi-cycle add/subtract unit: processes DIGIT bits per clock, LSB digit
// first, through one shared digit adder. Keeps a persistent carry flag so
// ADC/SBC can chain multi-word arithmetic.
// Ports:
//   clk, rst_n   : clock, synchronous active-low reset
//   start        : request, sampled only in IDLE
//   op           : 00 ADD, 01 SUB, 10 ADC, 11 SBC
//   a, b         : operands, latched on accept
//   busy         : high while running
//   done         : one-cycle pulse when res/flags update
//   res          : registered result
//   v, c, n, z   : overflow, carry (1 = no borrow on subtract), negative, zero
module au_serial
    import au_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] res,
    output logic             v,
    output logic             c,
    output logic             n,
    output logic             z
);

    localparam int unsigned K     = WIDTH / DIGIT;
    localparam int unsigned CNT_W = (K > 1) ? $clog2(K) : 1;

    au_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] res_q, res_d;
    au_flags_t        flags_q, flags_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [DIGIT-1:0] dig_a, dig_b, dig_sum;
    logic             dig_cout, dig_cmsb;
    logic [WIDTH-1:0] fin;

    assign dig_a = a_q[cnt_q * DIGIT +: DIGIT];
    assign dig_b = b_q[cnt_q * DIGIT +: DIGIT];

    au_digit_add #(.DIGIT(DIGIT)) u_digit (
        .a     (dig_a),
        .b     (dig_b),
        .cin   (carry_q),
        .sum   (dig_sum),
        .cout  (dig_cout),
        .c_msb (dig_cmsb)
    );

    // Full result as it stands once the top digit lands.
    always_comb begin
        fin = acc_q;
        fin[(K-1)*DIGIT +: DIGIT] = dig_sum;
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            acc_q   <= '0;
            res_q   <= '0;
            flags_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            acc_q   <= acc_d;
            res_q   <= res_d;
            flags_q <= flags_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        acc_d   = acc_q;
        res_d   = res_q;
        flags_d = flags_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    cnt_d   = '0;
                    state_d = RUN;
                    busy_d  = 1'b1;
                    // flags_q.c already holds a carry written in a done cycle.
                    case (op)
                        OP_ADD:  begin b_d = b;  carry_d = 1'b0;      end
                        OP_SUB:  begin b_d = ~b; carry_d = 1'b1;      end
                        OP_ADC:  begin b_d = b;  carry_d = flags_q.c; end
                        default: begin b_d = ~b; carry_d = flags_q.c; end
                    endcase
                end
            end
            RUN: begin
                busy_d = 1'b1;
                acc_d[cnt_q * DIGIT +: DIGIT] = dig_sum;
                carry_d = dig_cout;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(K - 1)) begin
                    state_d   = IDLE;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    res_d     = fin;
                    flags_d.c = dig_cout;
                    flags_d.v = dig_cmsb ^ dig_cout;
                    flags_d.n = fin[WIDTH-1];
                    flags_d.z = (fin == '0);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy = busy_q;
    assign done = done_q;
    assign res  = res_q;
    assign v    = flags_q.v;
    assign c    = flags_q.c;
    assign n    = flags_q.n;
    assign z    = flags_q.z;

endmodule

// File: tb/tb_au_serial.sv
// Directed bench for au_serial at default size, plus K=1 (8/8) and a 32/2
// instance checked against a plain arithmetic model.
module tb_au_serial;
    import au_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Default instance (16/4, K=4)
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [15:0] a = '0, b = '0;
    logic        busy, done, v, c, n, z;
    logic [15:0] res;

    au_serial u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .res(res), .v(v), .c(c), .n(n), .z(z)
    );

    // K = 1 instance
    logic       start8 = 1'b0;
    logic [1:0] op8 = 2'b00;
    logic [7:0] a8 = '0, b8 = '0;
    logic       busy8, done8, v8, c8, n8, z8;
    logic [7:0] res8;

    au_serial #(.WIDTH(8), .DIGIT(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .op(op8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .res(res8), .v(v8), .c(c8), .n(n8), .z(z8)
    );

    // 32/2 instance, K = 16
    logic        start32 = 1'b0;
    logic [1:0]  op32 = 2'b00;
    logic [31:0] a32 = '0, b32 = '0;
    logic        busy32, done32, v32, c32, n32, z32;
    logic [31:0] res32;

    au_serial #(.WIDTH(32), .DIGIT(2)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .start(start32), .op(op32), .a(a32), .b(b32),
        .busy(busy32), .done(done32), .res(res32), .v(v32), .c(c32), .n(n32), .z(z32)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive a request for one edge; returns in the first RUN cycle.
    task automatic start_op(input logic [1:0] o, input logic [15:0] x, input logic [15:0] y);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        tick();
        start = 1'b0;
        op    = 2'bxx;
        a     = 'x;
        b     = 'x;
    endtask

    // Cycles from accept edge to the done cycle, bounded.
    task automatic wait_done(output int lat);
        lat = 1;
        while (!done && lat < 30) begin
            tick();
            lat++;
        end
    endtask

    task automatic do_op(input string tag, input logic [1:0] o, input logic [15:0] x,
                         input logic [15:0] y, input logic [15:0] er, input logic [3:0] ef);
        int lat;
        start_op(o, x, y);
        wait_done(lat);
        chk({tag, "_lat"}, 64'(lat), 64'd5);
        chk({tag, "_res"}, 64'(res), 64'(er));
        chk({tag, "_vcnz"}, 64'({v, c, n, z}), 64'(ef));
    endtask

    initial begin
        int lat, cnt, last, bad;
        logic [31:0] bp, rm;
        logic [32:0] sm;
        logic        cm, cin;
        logic [3:0]  fm;

        // Reset
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_res", 64'(res), 64'd0);
        chk("rst_vcnz", 64'({v, c, n, z}), 64'd0);
        tick();

        // ADD overflow, with busy/done timing
        start_op(OP_ADD, 16'h7FFF, 16'h0001);
        for (int i = 1; i <= 4; i++) begin
            chk("add_busy", 64'(busy), 64'd1);
            chk("add_nodone", 64'(done), 64'd0);
            tick();
        end
        chk("add_done", 64'(done), 64'd1);
        chk("add_busy_off", 64'(busy), 64'd0);
        chk("add_res", 64'(res), 64'h8000);
        chk("add_vcnz", 64'({v, c, n, z}), 64'b1010);
        tick();
        chk("add_pulse", 64'(done), 64'd0);
        chk("add_hold", 64'(res), 64'h8000);

        // Subtract
        do_op("sub_eq", OP_SUB, 16'h0005, 16'h0005, 16'h0000, 4'b0101);
        tick();
        do_op("sub_neg", OP_SUB, 16'h0003, 16'h0005, 16'hFFFE, 4'b0010);
        tick();

        // Carry chain, back-to-back from done cycles
        do_op("chain_add", OP_ADD, 16'hFFFF, 16'h0001, 16'h0000, 4'b0101);
        do_op("chain_adc", OP_ADC, 16'h0000, 16'h0000, 16'h0001, 4'b0000);
        do_op("chain_sbc", OP_SBC, 16'h0000, 16'h0000, 16'hFFFF, 4'b0010);
        tick();

        // start during RUN is ignored
        start_op(OP_ADD, 16'h0001, 16'h0002);
        start = 1'b1; op = OP_SUB; a = 16'hFFFF; b = 16'h0001;
        tick();
        start = 1'b0;
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            if (done) begin
                cnt++;
                chk("ign_res", 64'(res), 64'h0003);
                chk("ign_vcnz", 64'({v, c, n, z}), 64'b0000);
            end
            tick();
        end
        chk("ign_ndone", 64'(cnt), 64'd1);

        // start held high: done every 5 cycles, outputs stable in between
        start = 1'b1; op = OP_ADD; a = 16'h1234; b = 16'h1111;
        cnt = 0; last = 0; bad = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (done) begin
                if (cnt > 0) chk("hold_gap", 64'(i - last), 64'd5);
                last = i;
                cnt++;
            end
            if (cnt > 0 && (res !== 16'h2345 || {v, c, n, z} !== 4'b0000)) bad++;
        end
        start = 1'b0;
        chk("hold_ndone", 64'(cnt), 64'd4);
        chk("hold_stable", 64'(bad), 64'd0);
        tick();

        // Reset during second RUN cycle
        start_op(OP_ADD, 16'h1111, 16'h2222);
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("mrst_busy", 64'(busy), 64'd0);
        chk("mrst_done", 64'(done), 64'd0);
        chk("mrst_res", 64'(res), 64'd0);
        chk("mrst_vcnz", 64'({v, c, n, z}), 64'd0);
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            if (done) cnt++;
            tick();
        end
        chk("mrst_nodone", 64'(cnt), 64'd0);
        do_op("mrst_add", OP_ADD, 16'h1111, 16'h2222, 16'h3333, 4'b0000);
        tick();

        // K = 1: done at start+2
        start8 = 1'b1; op8 = OP_ADD; a8 = 8'h80; b8 = 8'h80;
        tick();
        start8 = 1'b0;
        chk("k1_busy", 64'(busy8), 64'd1);
        chk("k1_nodone", 64'(done8), 64'd0);
        tick();
        chk("k1_done", 64'(done8), 64'd1);
        chk("k1_res", 64'(res8), 64'h00);
        chk("k1_vcnz", 64'({v8, c8, n8, z8}), 64'b1101);
        start8 = 1'b1; op8 = OP_SUB; a8 = 8'h10; b8 = 8'h20;
        tick();
        start8 = 1'b0;
        tick();
        chk("k1_sub_done", 64'(done8), 64'd1);
        chk("k1_sub_res", 64'(res8), 64'hF0);
        chk("k1_sub_vcnz", 64'({v8, c8, n8, z8}), 64'b0010);
        tick();

        // 32/2: random ops against an arithmetic model, carry tracked across ops
        cm = 1'b0;
        for (int k = 0; k < 500; k++) begin
            op32 = 2'($urandom_range(0, 3));
            case (k % 8)
                0:       begin a32 = 32'hFFFF_FFFF; b32 = 32'h0000_0001; end
                1:       begin a32 = 32'h7FFF_FFFF; b32 = 32'h7FFF_FFFF; end
                2:       begin a32 = 32'h8000_0000; b32 = 32'h8000_0000; end
                default: begin a32 = $urandom; b32 = $urandom; end
            endcase
            bp  = op32[0] ? ~b32 : b32;
            cin = op32[1] ? cm : op32[0];
            sm  = {1'b0, a32} + {1'b0, bp} + 33'(cin);
            rm  = sm[31:0];
            fm  = {(a32[31] == bp[31]) && (rm[31] != a32[31]), sm[32], rm[31], rm == 32'd0};
            cm  = sm[32];
            start32 = 1'b1;
            tick();
            start32 = 1'b0;
            lat = 1;
            while (!done32 && lat < 40) begin
                tick();
                lat++;
            end
            chk("w32_lat", 64'(lat), 64'd17);
            chk("w32_res", 64'(res32), 64'(rm));
            chk("w32_vcnz", 64'({v32, c32, n32, z32}), 64'(fm));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
